ctrl_decode_pipe: RTL and testbench
===================================

Name: ctrl_decode_pipe

Overview:
- Registered successor to the combinational RV32I control decoder.
- Decodes opcode, funct3 and funct7 into the datapath control bundle.
- Holds the bundle in the ID/EX pipeline register, with stall and flush support.
- Optionally supports the M-extension, holding MUL/DIV ops for a parametrised multi-cycle latency while back-pressuring the front end.

Parameters:
ALU_OP_W, 3, alu_op width; must be >= 3. When ALU_OP_W > 3, bit 3 = funct7[5] for OP and for OP-IMM funct3=101; all other upper bits are 0.
ENABLE_M, 1, 1 = decode RV32M (OP with funct7=0000001); 0 = treat it as illegal.
MD_LATENCY, 4, cycles a MUL/DIV occupies the EX stage; range 1..15.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  instruction fields are valid this cycle
opcode  in  7  instruction[6:0]
fun_3  in  3  instruction[14:12]
fun_7  in  7  instruction[31:25]
stall_in  in  1  downstream hazard stall; hold the register
flush_in  in  1  branch/jump redirect; kill the register contents
valid_out  out  1  registered bundle is a live instruction
d_mem_r, d_mem_w, jump, branch, wrten_reg  out  1 each  registered controls
mux_complmnt, mux_inp_1, mux_inp_2, mux_d_mem  out  1 each  registered mux selects
mux_result  out  2  writeback source: 1 = imm, 2 = ALU/mem, 3 = PC+4
mux_wire_module  out  3  immediate-type select
alu_op  out  ALU_OP_W  ALU function
md_en  out  1  bundle is a MUL/DIV op
md_op  out  3  MUL/DIV funct3
illegal_out  out  1  one-cycle pulse: rejected instruction
stall_req  out  1  front end must hold; the unit is busy with MUL/DIV

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0; FSM enters RUN; counter = 0.
- Decode table (fields: wrten / mux_d_mem / mux_result / mux_inp_2 / mux_inp_1 / mux_wire_module; alu_op = 0 unless stated):
  - LUI 0110111: 1/1/1/0/0/3.
  - AUIPC 0010111: 1/1/2/1/1/3.
  - JAL 1101111: jump=1; 1/1/3/1/1/1.
  - JALR 1100111: jump=1; 1/1/3/1/0/4.
  - BRANCH 1100011: branch=1, mux_complmnt=1; 0/0/0/0/0/0.
  - LOAD 0000011: d_mem_r=1; 1/0/2/1/0/4.
  - STORE 0100011: d_mem_w=1; 0/0/2/1/0/2.
  - OP-IMM 0010011: 1/1/2/1/0/4; alu_op = fun_3.
  - OP 0110011: 1/1/2/0/0/0; alu_op = fun_3; mux_complmnt = fun_7[5].
  - M op (OP with fun_7=0000001, ENABLE_M=1): OP row, plus md_en=1, md_op=fun_3, mux_complmnt=0.
- Illegal instructions: any other opcode, OP with any other fun_7, or an M op with ENABLE_M=0.
  - The register loads a bubble: all controls 0, valid_out 0.
  - illegal_out=1 for exactly one cycle.
- Register update priority each cycle:
  1. flush_in: load bubble; valid_out=0; abort MD_WAIT -> RUN; stall_req=0 next cycle.
  2. stall_in: hold all outputs unchanged, including illegal_out=0. The MD counter also freezes.
  3. RUN with valid_in: load the decoded bundle; valid_out=1.
  4. RUN with !valid_in: load bubble.
- FSM RUN -> MD_WAIT:
  - Taken when an M op loads and MD_LATENCY > 1.
  - Counter loads MD_LATENCY-1.
  - stall_req=1 from the next cycle.
  - wrten_reg is held 0 while the counter is nonzero.
- MD_WAIT:
  - The bundle is held with valid_out=1, and valid_in is ignored.
  - The counter decrements each non-stalled cycle.
  - At counter=0: wrten_reg=1 for that one cycle, stall_req=0, return to RUN.
  - The next valid_in is accepted on the following edge.
- MD_LATENCY=1: an M op behaves like a single-cycle OP; MD_WAIT is never entered.
- Simultaneous flush_in and stall_in: flush wins.
- Simultaneous flush_in and valid_in: the instruction is dropped.

Test Plan:
- Reset mid-MD_WAIT (reset_n low for 1 cycle, counter=2) -> all outputs 0 immediately; stall_req=0; next ADD decodes normally.
- Stream LUI, JAL, LOAD, STORE with valid_in=1 -> one cycle later each shows mux_result 1, 3, 2, 2 and mux_wire_module 3, 1, 4, 2 respectively; valid_out=1.
- SUB (OP, fun_7=0100000, fun_3=000), ALU_OP_W=4 -> mux_complmnt=1, alu_op=4'b1000, wrten_reg=1.
- MUL with MD_LATENCY=4 -> stall_req high 3 cycles; wrten_reg=0 for 3 cycles, then 1 for 1 cycle with md_en=1, md_op=000; the next instruction loads after that.
- DIV issued, then flush_in on the 2nd MD_WAIT cycle -> bubble next cycle, stall_req=0, state RUN; also stall_in held 2 cycles during the wait extends stall_req by 2.
- Opcode 1111111, and MUL with ENABLE_M=0 -> illegal_out pulses 1 cycle; valid_out=0; all enables 0.

Source files
------------

// File: rtl/ctrl_decode_pipe_if.sv
// Front-end to ID/EX control interface: instruction fields plus pipeline
// controls in, the registered datapath control bundle out.
interface ctrl_decode_pipe_if #(
  parameter int unsigned ALU_OP_W = 3
);
  logic                valid_in;
  logic [6:0]          opcode;
  logic [2:0]          fun_3;
  logic [6:0]          fun_7;
  logic                stall_in;
  logic                flush_in;

  logic                valid_out;
  logic                d_mem_r;
  logic                d_mem_w;
  logic                jump;
  logic                branch;
  logic                wrten_reg;
  logic                mux_complmnt;
  logic                mux_inp_1;
  logic                mux_inp_2;
  logic                mux_d_mem;
  logic [1:0]          mux_result;
  logic [2:0]          mux_wire_module;
  logic [ALU_OP_W-1:0] alu_op;
  logic                md_en;
  logic [2:0]          md_op;
  logic                illegal_out;
  logic                stall_req;

  modport master (
    output valid_in, opcode, fun_3, fun_7, stall_in, flush_in,
    input  valid_out, d_mem_r, d_mem_w, jump, branch, wrten_reg,
           mux_complmnt, mux_inp_1, mux_inp_2, mux_d_mem, mux_result,
           mux_wire_module, alu_op, md_en, md_op, illegal_out, stall_req
  );

  modport slave (
    input  valid_in, opcode, fun_3, fun_7, stall_in, flush_in,
    output valid_out, d_mem_r, d_mem_w, jump, branch, wrten_reg,
           mux_complmnt, mux_inp_1, mux_inp_2, mux_d_mem, mux_result,
           mux_wire_module, alu_op, md_en, md_op, illegal_out, stall_req
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// RV32I(M) control decoder feeding the ID/EX register, with stall/flush and
// a multi-cycle MUL/DIV hold that back-pressures the front end.
module ctrl_decode_pipe #(
  parameter int unsigned ALU_OP_W   = 3,
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MD_LATENCY = 4
) (
  input logic          clk,
  input logic          reset_n,
  ctrl_decode_pipe_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {RUN, MD_WAIT} state_t;

  typedef struct packed {
    logic                d_mem_r;
    logic                d_mem_w;
    logic                jump;
    logic                branch;
    logic                wrten_reg;
    logic                mux_complmnt;
    logic                mux_inp_1;
    logic                mux_inp_2;
    logic                mux_d_mem;
    logic [1:0]          mux_result;
    logic [2:0]          mux_wire_module;
    logic [ALU_OP_W-1:0] alu_op;
    logic                md_en;
    logic [2:0]          md_op;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d, dec;
  logic       valid_q, valid_d, illegal_q, illegal_d;
  logic       dec_ok;
  logic [3:0] alu4;

  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    alu4   = '0;
    case (bus.opcode)
      OPC_LUI: begin
        dec.wrten_reg = 1'b1; dec.mux_d_mem = 1'b1;
        dec.mux_result = 2'd1; dec.mux_wire_module = 3'd3;
      end
      OPC_AUIPC: begin
        dec.wrten_reg = 1'b1; dec.mux_d_mem = 1'b1; dec.mux_result = 2'd2;
        dec.mux_inp_2 = 1'b1; dec.mux_inp_1 = 1'b1; dec.mux_wire_module = 3'd3;
      end
      OPC_JAL: begin
        dec.jump = 1'b1; dec.wrten_reg = 1'b1; dec.mux_d_mem = 1'b1; dec.mux_result = 2'd3;
        dec.mux_inp_2 = 1'b1; dec.mux_inp_1 = 1'b1; dec.mux_wire_module = 3'd1;
      end
      OPC_JALR: begin
        dec.jump = 1'b1; dec.wrten_reg = 1'b1; dec.mux_d_mem = 1'b1; dec.mux_result = 2'd3;
        dec.mux_inp_2 = 1'b1; dec.mux_wire_module = 3'd4;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1; dec.mux_complmnt = 1'b1;
      end
      OPC_LOAD: begin
        dec.d_mem_r = 1'b1; dec.wrten_reg = 1'b1; dec.mux_result = 2'd2;
        dec.mux_inp_2 = 1'b1; dec.mux_wire_module = 3'd4;
      end
      OPC_STORE: begin
        dec.d_mem_w = 1'b1; dec.mux_result = 2'd2;
        dec.mux_inp_2 = 1'b1; dec.mux_wire_module = 3'd2;
      end
      OPC_OPIMM: begin
        dec.wrten_reg = 1'b1; dec.mux_d_mem = 1'b1; dec.mux_result = 2'd2;
        dec.mux_inp_2 = 1'b1; dec.mux_wire_module = 3'd4;
        alu4 = {bus.fun_7[5] & (bus.fun_3 == 3'b101), bus.fun_3};
      end
      OPC_OP: begin
        dec.wrten_reg = 1'b1; dec.mux_d_mem = 1'b1; dec.mux_result = 2'd2;
        alu4 = {1'b0, bus.fun_3};
        if (bus.fun_7 == 7'b0000000 || bus.fun_7 == 7'b0100000) begin
          dec.mux_complmnt = bus.fun_7[5];
          alu4[3]          = bus.fun_7[5];
        end else if (bus.fun_7 == 7'b0000001 && ENABLE_M) begin
          dec.md_en = 1'b1;
          dec.md_op = bus.fun_3;
        end else begin
          dec_ok = 1'b0;
        end
      end
      default: dec_ok = 1'b0;
    endcase
    // The funct7[5] extension bit only survives when alu_op is wider than 3.
    dec.alu_op = ALU_OP_W'(alu4);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    if (bus.flush_in) begin
      state_d = RUN;
      cnt_d   = '0;
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (bus.stall_in) begin
      illegal_d = 1'b0;
    end else if (state_q == MD_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d          = RUN;
        ctrl_d.wrten_reg = 1'b1;
      end
    end else if (bus.valid_in && dec_ok) begin
      ctrl_d  = dec;
      valid_d = 1'b1;
      // Result write-back is deferred until the MUL/DIV countdown expires.
      if (dec.md_en && MD_LATENCY > 1) begin
        state_d          = MD_WAIT;
        cnt_d            = 4'(MD_LATENCY - 1);
        ctrl_d.wrten_reg = 1'b0;
      end
    end else begin
      ctrl_d    = '0;
      valid_d   = 1'b0;
      illegal_d = bus.valid_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.valid_out       = valid_q;
  assign bus.d_mem_r         = ctrl_q.d_mem_r;
  assign bus.d_mem_w         = ctrl_q.d_mem_w;
  assign bus.jump            = ctrl_q.jump;
  assign bus.branch          = ctrl_q.branch;
  assign bus.wrten_reg       = ctrl_q.wrten_reg;
  assign bus.mux_complmnt    = ctrl_q.mux_complmnt;
  assign bus.mux_inp_1       = ctrl_q.mux_inp_1;
  assign bus.mux_inp_2       = ctrl_q.mux_inp_2;
  assign bus.mux_d_mem       = ctrl_q.mux_d_mem;
  assign bus.mux_result      = ctrl_q.mux_result;
  assign bus.mux_wire_module = ctrl_q.mux_wire_module;
  assign bus.alu_op          = ctrl_q.alu_op;
  assign bus.md_en           = ctrl_q.md_en;
  assign bus.md_op           = ctrl_q.md_op;
  assign bus.illegal_out     = illegal_q;
  assign bus.stall_req       = (state_q == MD_WAIT);
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench: two decoder instances (4-bit alu_op with RV32M, and
// 3-bit alu_op without RV32M) driven by the same instruction stream.
module tb_ctrl_decode_pipe;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_in, stall_in, flush_in;
  logic [6:0] opcode, fun_7;
  logic [2:0] fun_3;
  int         n_checks = 0;
  int         n_errors = 0;

  ctrl_decode_pipe_if #(.ALU_OP_W(4)) bus_a ();
  ctrl_decode_pipe_if #(.ALU_OP_W(3)) bus_b ();

  assign bus_a.valid_in = valid_in;
  assign bus_a.opcode   = opcode;
  assign bus_a.fun_3    = fun_3;
  assign bus_a.fun_7    = fun_7;
  assign bus_a.stall_in = stall_in;
  assign bus_a.flush_in = flush_in;
  assign bus_b.valid_in = valid_in;
  assign bus_b.opcode   = opcode;
  assign bus_b.fun_3    = fun_3;
  assign bus_b.fun_7    = fun_7;
  assign bus_b.stall_in = stall_in;
  assign bus_b.flush_in = flush_in;

  ctrl_decode_pipe #(.ALU_OP_W(4), .ENABLE_M(1'b1), .MD_LATENCY(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );
  ctrl_decode_pipe #(.ALU_OP_W(3), .ENABLE_M(1'b0), .MD_LATENCY(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    valid_in = v; opcode = op; fun_3 = f3; fun_7 = f7;
  endtask

  initial begin
    reset_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    instr(1'b0, 7'd0, 3'd0, 7'd0);
    step(); step();
    chk("rst_valid",   bus_a.valid_out, 0);
    chk("rst_stall",   bus_a.stall_req, 0);
    chk("rst_wrten",   bus_a.wrten_reg, 0);
    chk("rst_illegal", bus_a.illegal_out, 0);
    reset_n = 1'b1;

    // LUI, JAL, LOAD, STORE stream
    instr(1'b1, 7'b0110111, 3'd0, 7'd0); step();
    chk("lui_res", bus_a.mux_result, 1);
    chk("lui_imm", bus_a.mux_wire_module, 3);
    chk("lui_vld", bus_a.valid_out, 1);
    chk("lui_wr",  bus_a.wrten_reg, 1);
    instr(1'b1, 7'b1101111, 3'd0, 7'd0); step();
    chk("jal_res",  bus_a.mux_result, 3);
    chk("jal_imm",  bus_a.mux_wire_module, 1);
    chk("jal_jump", bus_a.jump, 1);
    chk("jal_inp1", bus_a.mux_inp_1, 1);
    instr(1'b1, 7'b0000011, 3'd2, 7'd0); step();
    chk("ld_res", bus_a.mux_result, 2);
    chk("ld_imm", bus_a.mux_wire_module, 4);
    chk("ld_rd",  bus_a.d_mem_r, 1);
    chk("ld_dm",  bus_a.mux_d_mem, 0);
    instr(1'b1, 7'b0100011, 3'd2, 7'd0); step();
    chk("st_res", bus_a.mux_result, 2);
    chk("st_imm", bus_a.mux_wire_module, 2);
    chk("st_wr",  bus_a.d_mem_w, 1);
    chk("st_wrten", bus_a.wrten_reg, 0);
    chk("st_vld", bus_a.valid_out, 1);

    // SUB: funct7[5] into complement and alu_op[3]
    instr(1'b1, 7'b0110011, 3'b000, 7'b0100000); step();
    chk("sub_cmp",   bus_a.mux_complmnt, 1);
    chk("sub_alu",   bus_a.alu_op, 8);
    chk("sub_wr",    bus_a.wrten_reg, 1);
    chk("sub_alu_b", bus_b.alu_op, 0);
    // SRAI gets alu_op[3]; ADDI with the same funct7 does not
    instr(1'b1, 7'b0010011, 3'b101, 7'b0100000); step();
    chk("srai_alu", bus_a.alu_op, 13);
    chk("srai_cmp", bus_a.mux_complmnt, 0);
    chk("srai_i2",  bus_a.mux_inp_2, 1);
    instr(1'b1, 7'b0010011, 3'b000, 7'b0100000); step();
    chk("addi_alu", bus_a.alu_op, 0);

    // MUL, latency 4 on dut_a; illegal on dut_b
    instr(1'b1, 7'b0110011, 3'b000, 7'b0000001); step();
    chk("mul0_md",    bus_a.md_en, 1);
    chk("mul0_op",    bus_a.md_op, 0);
    chk("mul0_wr",    bus_a.wrten_reg, 0);
    chk("mul0_stall", bus_a.stall_req, 1);
    chk("mul0_cmp",   bus_a.mux_complmnt, 0);
    chk("mulb_ill",   bus_b.illegal_out, 1);
    chk("mulb_vld",   bus_b.valid_out, 0);
    chk("mulb_wr",    bus_b.wrten_reg, 0);
    chk("mulb_md",    bus_b.md_en, 0);
    instr(1'b1, 7'b0110011, 3'b000, 7'b0000000); step();
    chk("mul1_stall", bus_a.stall_req, 1);
    chk("mul1_wr",    bus_a.wrten_reg, 0);
    chk("mul1_vld",   bus_a.valid_out, 1);
    chk("mulb_pulse", bus_b.illegal_out, 0);
    step();
    chk("mul2_stall", bus_a.stall_req, 1);
    chk("mul2_wr",    bus_a.wrten_reg, 0);
    step();
    chk("mul3_stall", bus_a.stall_req, 0);
    chk("mul3_wr",    bus_a.wrten_reg, 1);
    chk("mul3_md",    bus_a.md_en, 1);
    step();
    chk("add_md",  bus_a.md_en, 0);
    chk("add_wr",  bus_a.wrten_reg, 1);
    chk("add_vld", bus_a.valid_out, 1);

    // DIV, stall for 2 cycles, then flush with stall and valid both high
    instr(1'b1, 7'b0110011, 3'b100, 7'b0000001); step();
    chk("div_stall", bus_a.stall_req, 1);
    chk("div_op",    bus_a.md_op, 4);
    instr(1'b0, 7'd0, 3'd0, 7'd0);
    stall_in = 1'b1; step();
    chk("divs1_stall", bus_a.stall_req, 1);
    step();
    chk("divs2_stall", bus_a.stall_req, 1);
    chk("divs2_op",    bus_a.md_op, 4);
    stall_in = 1'b0; step();
    chk("divw_stall", bus_a.stall_req, 1);
    chk("divw_wr",    bus_a.wrten_reg, 0);
    flush_in = 1'b1; stall_in = 1'b1;
    instr(1'b1, 7'b0110011, 3'b000, 7'b0000000); step();
    chk("fl_vld",   bus_a.valid_out, 0);
    chk("fl_stall", bus_a.stall_req, 0);
    chk("fl_md",    bus_a.md_en, 0);
    chk("fl_wr",    bus_a.wrten_reg, 0);
    flush_in = 1'b0; stall_in = 1'b0; step();
    chk("afl_vld", bus_a.valid_out, 1);
    chk("afl_wr",  bus_a.wrten_reg, 1);

    // Stall in RUN holds the register
    instr(1'b1, 7'b0110111, 3'd0, 7'd0); step();
    stall_in = 1'b1;
    instr(1'b1, 7'b1101111, 3'd0, 7'd0); step();
    chk("hold_res",  bus_a.mux_result, 1);
    chk("hold_jump", bus_a.jump, 0);
    stall_in = 1'b0;

    // Illegal opcode
    instr(1'b1, 7'b1111111, 3'd0, 7'd0); step();
    chk("ill_pulse", bus_a.illegal_out, 1);
    chk("ill_vld",   bus_a.valid_out, 0);
    chk("ill_wr",    bus_a.wrten_reg, 0);
    chk("ill_res",   bus_a.mux_result, 0);
    instr(1'b0, 7'd0, 3'd0, 7'd0); step();
    chk("ill_end",   bus_a.illegal_out, 0);

    // Asynchronous reset in the middle of a MUL wait (counter = 2)
    instr(1'b1, 7'b0110011, 3'b000, 7'b0000001); step();
    instr(1'b0, 7'd0, 3'd0, 7'd0); step();
    chk("prer_stall", bus_a.stall_req, 1);
    reset_n = 1'b0; #1;
    chk("ar_vld",   bus_a.valid_out, 0);
    chk("ar_stall", bus_a.stall_req, 0);
    chk("ar_md",    bus_a.md_en, 0);
    #2 reset_n = 1'b1;
    instr(1'b1, 7'b0110011, 3'b000, 7'b0000000); step();
    chk("par_vld",   bus_a.valid_out, 1);
    chk("par_wr",    bus_a.wrten_reg, 1);
    chk("par_stall", bus_a.stall_req, 0);
    chk("par_md",    bus_a.md_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
